id_ex_stage: RTL

ID/EX pipeline stage of the five-stage pipelined CPU. Sits directly downstream of the register file. Each cycle it does four things:
- captures the decoded instruction and the two register-file read operands;
- applies a write-through bypass from the writeback port, because the register file writes on the clock edge and reads combinationally;
- detects load-use hazards and inserts a one-cycle bubble into EX;
- counts inserted bubbles.

---
 rtl/id_ex_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use hazard detection and
// a saturating count of the load-use bubbles it inserts.
module id_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [31:0]      pc_i,
  input  logic [4:0]       RSaddr_i,
  input  logic [4:0]       RTaddr_i,
  input  logic             UseRS_i,
  input  logic             UseRT_i,
  input  logic [4:0]       RDaddr_i,
  input  logic [31:0]      RSdata_i,
  input  logic [31:0]      RTdata_i,
  input  logic [31:0]      imm_i,
  input  logic             RegWrite_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             MemtoReg_i,
  input  logic             ALUSrc_i,
  input  logic [2:0]       ALUOp_i,
  input  logic             WB_RegWrite_i,
  input  logic [4:0]       WB_RDaddr_i,
  input  logic [31:0]      WB_RDdata_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [31:0]      pc_o,
  output logic [4:0]       RSaddr_o,
  output logic [4:0]       RTaddr_o,
  output logic [4:0]       RDaddr_o,
  output logic [31:0]      RSdata_o,
  output logic [31:0]      RTdata_o,
  output logic [31:0]      imm_o,
  output logic             RegWrite_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             MemtoReg_o,
  output logic             ALUSrc_o,
  output logic [2:0]       ALUOp_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  // EX-stage state
  logic             valid_q, valid_d;
  logic [31:0]      pc_q, pc_d;
  logic [4:0]       rs_addr_q, rs_addr_d;
  logic [4:0]       rt_addr_q, rt_addr_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [31:0]      rs_data_q, rs_data_d;
  logic [31:0]      rt_data_q, rt_data_d;
  logic [31:0]      imm_q, imm_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             alu_src_q, alu_src_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        rs_hit, rt_hit;
  logic [31:0] rs_byp, rt_byp;
  logic        rs_dep, rt_dep;
  logic        hz;
  logic        bubble;
  logic        ctl_en;
  logic        cnt_sat;

  // Register file writes on the edge and reads combinationally, so a value being
  // written this cycle must be picked up here; r0 is hardwired and never bypassed.
  always_comb begin
    rs_hit = WB_RegWrite_i && (WB_RDaddr_i != 5'd0) && (WB_RDaddr_i == RSaddr_i);
    rt_hit = WB_RegWrite_i && (WB_RDaddr_i != 5'd0) && (WB_RDaddr_i == RTaddr_i);
    rs_byp = rs_hit ? WB_RDdata_i : RSdata_i;
    rt_byp = rt_hit ? WB_RDdata_i : RTdata_i;
  end

  always_comb begin
    rs_dep  = UseRS_i && (RSaddr_i == rd_addr_q);
    rt_dep  = UseRT_i && (RTaddr_i == rd_addr_q);
    hz      = valid_q && mem_read_q && (rd_addr_q != 5'd0) && valid_i && (rs_dep || rt_dep);
    stall_o = hz && !flush_i;
    bubble  = flush_i || hz;
    ctl_en  = valid_i && !bubble;
    cnt_sat = (cnt_q == {CNT_W{1'b1}});
  end

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs_addr_d    = rs_addr_q;
    rt_addr_d    = rt_addr_q;
    rd_addr_d    = rd_addr_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_src_d    = alu_src_q;
    alu_op_d     = alu_op_q;
    cnt_d        = cnt_q;

    if (!stall_i) begin
      // Data fields are captured even on a bubble; only valid and control matter there.
      pc_d         = pc_i;
      rs_addr_d    = RSaddr_i;
      rt_addr_d    = RTaddr_i;
      rd_addr_d    = RDaddr_i;
      rs_data_d    = rs_byp;
      rt_data_d    = rt_byp;
      imm_d        = imm_i;
      valid_d      = ctl_en;
      reg_write_d  = RegWrite_i && ctl_en;
      mem_read_d   = MemRead_i && ctl_en;
      mem_write_d  = MemWrite_i && ctl_en;
      mem_to_reg_d = MemtoReg_i && ctl_en;
      alu_src_d    = ALUSrc_i && ctl_en;
      alu_op_d     = ctl_en ? ALUOp_i : 3'd0;
      if (hz && !flush_i && !cnt_sat) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      rd_addr_q    <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= '0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs_addr_q    <= rs_addr_d;
      rt_addr_q    <= rt_addr_d;
      rd_addr_q    <= rd_addr_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      cnt_q        <= cnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign pc_o         = pc_q;
  assign RSaddr_o     = rs_addr_q;
  assign RTaddr_o     = rt_addr_q;
  assign RDaddr_o     = rd_addr_q;
  assign RSdata_o     = rs_data_q;
  assign RTdata_o     = rt_data_q;
  assign imm_o        = imm_q;
  assign RegWrite_o   = reg_write_q;
  assign MemRead_o    = mem_read_q;
  assign MemWrite_o   = mem_write_q;
  assign MemtoReg_o   = mem_to_reg_q;
  assign ALUSrc_o     = alu_src_q;
  assign ALUOp_o      = alu_op_q;
  assign bubble_cnt_o = cnt_q;

endmodule
